ap_hs_latency_probe: RTL and testbench
======================================

AP_HS_LATENCY_PROBE -- requirements
Module: ap_hs_latency_probe

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of latency, interval and iteration fields.
REQ-002 SHALL have parameter DEPTH, default 4, record FIFO depth; power of two, at least 2.
REQ-003 SHALL have port ap_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port enable, input, 1, permits new transactions to start.
REQ-006 SHALL have port mon_start, input, 1, observed ap_start of the kernel.
REQ-007 SHALL have port mon_done, input, 1, observed ap_done of the kernel.
REQ-008 SHALL have port mon_iter, input, 1, single-cycle pulse per loop iteration start.
REQ-009 SHALL have port busy, output, 1, high while a transaction is in flight.
REQ-010 SHALL have port rec_valid, output, 1, a record is presented.
REQ-011 SHALL have port rec_ready, input, 1, consumer accepts the record.
REQ-012 SHALL have port rec_latency, output, CNT_W, done cycle minus start cycle.
REQ-013 SHALL have port rec_interval, output, CNT_W, start-to-start cycles.
REQ-014 SHALL have port rec_iters, output, CNT_W, mon_iter pulses in the transaction.
REQ-015 SHALL have port rec_seq, output, 16, transaction sequence number.
REQ-016 SHALL have port drop_cnt, output, 16, records lost to a full FIFO.

Function
REQ-017 SHALL implement FSM IDLE/ACTIVE; IDLE->ACTIVE when mon_start & enable & !mon_done; IDLE stays IDLE and emits record when mon_start & enable & mon_done (latency 0).
REQ-018 SHALL return ACTIVE->IDLE on the first cycle mon_done=1; mon_start in ACTIVE SHALL be ignored.
REQ-019 SHALL drive busy=1 exactly when state is ACTIVE.
REQ-020 SHALL keep a free-running CNT_W cycle counter wrapping modulo 2^CNT_W; interval SHALL use modular subtraction.
REQ-021 SHALL count latency from 0 at the start cycle, incrementing each ACTIVE cycle, saturating at all-ones.
REQ-022 SHALL report rec_interval=0 for the first transaction after reset, else start cycle minus previous start cycle.
REQ-023 SHALL count mon_iter pulses from the start cycle through the done cycle inclusive, saturating at all-ones; pulses in IDLE otherwise ignored.
REQ-024 SHALL assign rec_seq from a 16-bit counter starting at 0, incremented per completed transaction, wrapping, including dropped ones.
REQ-025 SHALL push the record into the FIFO on the done cycle; rec_valid visible the next cycle.
REQ-026 SHALL, when FIFO full and no pop that cycle, drop the record and increment drop_cnt saturating at 0xFFFF.
REQ-027 SHALL accept a push when full if a pop (rec_valid & rec_ready) occurs the same cycle.
REQ-028 SHALL hold rec_* stable while rec_valid & !rec_ready; rec_valid = FIFO not empty.
REQ-029 SHALL let an in-flight transaction complete normally when enable drops.

Reset
REQ-030 SHALL on ap_rst_n=0 asynchronously force IDLE, busy=0, rec_valid=0, FIFO empty, all counters and rec_* fields 0, first-transaction flag set.
REQ-031 SHALL discard an in-flight transaction on reset; no record emitted for it.

Verification
REQ-032 Start at cycle 5, done at cycle 15, 3 mon_iter pulses -> record latency=10, interval=0, iters=3, seq=0.
REQ-033 Second start at cycle 25, done 30 -> latency=5, interval=20, seq=1.
REQ-034 mon_start and mon_done in the same IDLE cycle -> latency=0, busy stays 0.
REQ-035 rec_ready=0, 5 transactions with DEPTH=4 -> 4 records held, drop_cnt=1, drained seq 0,1,2,3.
REQ-036 FIFO full, done coincides with pop -> record accepted, drop_cnt unchanged.
REQ-037 ap_rst_n low mid-ACTIVE -> busy=0 immediately, no record, next record seq=0 interval=0.

Source files
------------

// File: rtl/ap_hs_latency_probe.sv
// Latency/interval/iteration probe for an ap_ctrl_hs kernel handshake.
// Each completed transaction produces one record, buffered in a small FIFO.
module ap_hs_latency_probe #(
   parameter int CNT_W = 32,
   parameter int DEPTH = 4
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             enable,
   input  logic             mon_start,
   input  logic             mon_done,
   input  logic             mon_iter,
   output logic             busy,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [CNT_W-1:0] rec_latency,
   output logic [CNT_W-1:0] rec_interval,
   output logic [CNT_W-1:0] rec_iters,
   output logic [15:0]      rec_seq,
   output logic [15:0]      drop_cnt
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_t;

   typedef struct packed {
      logic [CNT_W-1:0] lat;
      logic [CNT_W-1:0] intv;
      logic [CNT_W-1:0] iters;
      logic [15:0]      seq;
   } rec_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             w_start;
   logic             w_done;

   logic [CNT_W-1:0] r_cyc;
   logic [CNT_W-1:0] r_prev_start;
   logic             r_first;
   logic [CNT_W-1:0] r_lat;
   logic [CNT_W-1:0] r_intv;
   logic [CNT_W-1:0] r_iters;
   logic [15:0]      r_seq;
   logic [15:0]      r_drop;

   rec_t             r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   logic [CNT_W-1:0] w_interval;
   logic [CNT_W-1:0] w_iters_done;
   rec_t             w_rec;
   rec_t             w_head;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   // NOTE: every output of this block is defaulted first so no path leaves a latch.
   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      w_start      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mon_start && enable) begin
               w_start = 1'b1;
               if (mon_done) w_done = 1'b1;
               else          w_next_state = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            busy = 1'b1;
            if (mon_done) begin
               w_done       = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Modular subtraction keeps the interval correct across counter wrap.
   assign w_interval   = r_first ? '0 : r_cyc - r_prev_start;
   assign w_iters_done = (mon_iter && r_iters != '1) ? r_iters + CNT_W'(1) : r_iters;

   always_comb begin
      w_rec.seq = r_seq;
      if (r_state == S_ACTIVE) begin
         w_rec.lat   = r_lat;
         w_rec.intv  = r_intv;
         w_rec.iters = w_iters_done;
      end else begin
         w_rec.lat   = '0;
         w_rec.intv  = w_interval;
         w_rec.iters = CNT_W'(mon_iter);
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = !w_empty && rec_ready;
   assign w_push  = w_done && (!w_full || w_pop);
   assign w_drop  = w_done && w_full && !w_pop;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state      <= S_IDLE;
         r_cyc        <= '0;
         r_prev_start <= '0;
         r_first      <= 1'b1;
         r_lat        <= '0;
         r_intv       <= '0;
         r_iters      <= '0;
         r_seq        <= '0;
         r_drop       <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
      end else begin
         r_state <= w_next_state;
         r_cyc   <= r_cyc + CNT_W'(1);

         if (w_start) begin
            r_prev_start <= r_cyc;
            r_first      <= 1'b0;
            r_intv       <= w_interval;
            r_lat        <= CNT_W'(1);
            r_iters      <= CNT_W'(mon_iter);
         end else if (r_state == S_ACTIVE) begin
            if (r_lat != '1) r_lat <= r_lat + CNT_W'(1);
            r_iters <= w_iters_done;
         end

         if (w_done) r_seq <= r_seq + 16'd1;
         if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is left unreset; outputs are masked while the FIFO is empty.
   always_ff @(posedge ap_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
   end

   assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
   assign rec_valid    = !w_empty;
   assign rec_latency  = w_empty ? '0 : w_head.lat;
   assign rec_interval = w_empty ? '0 : w_head.intv;
   assign rec_iters    = w_empty ? '0 : w_head.iters;
   assign rec_seq      = w_empty ? '0 : w_head.seq;
   assign drop_cnt     = r_drop;

endmodule

// File: tb/tb_ap_hs_latency_probe.sv
// Bench for ap_hs_latency_probe: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model with a record queue.
module tb_ap_hs_latency_probe;

   localparam int CNT_W = 32;
   localparam int DEPTH = 4;

   logic             ap_clk = 1'b0;
   logic             ap_rst_n;
   logic             enable;
   logic             mon_start;
   logic             mon_done;
   logic             mon_iter;
   logic             busy;
   logic             rec_valid;
   logic             rec_ready;
   logic [CNT_W-1:0] rec_latency;
   logic [CNT_W-1:0] rec_interval;
   logic [CNT_W-1:0] rec_iters;
   logic [15:0]      rec_seq;
   logic [15:0]      drop_cnt;

   ap_hs_latency_probe #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .enable      (enable),
      .mon_start   (mon_start),
      .mon_done    (mon_done),
      .mon_iter    (mon_iter),
      .busy        (busy),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_latency (rec_latency),
      .rec_interval(rec_interval),
      .rec_iters   (rec_iters),
      .rec_seq     (rec_seq),
      .drop_cnt    (drop_cnt)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [31:0] lat;
      logic [31:0] intv;
      logic [31:0] iters;
      logic [31:0] seq;
   } mrec_t;

   mrec_t       q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] t;
   logic [31:0] m_st;
   logic [31:0] m_prev;
   logic [31:0] m_intv;
   logic [31:0] m_iters;
   bit          m_active;
   bit          m_first;
   int          m_seq;
   int          m_drop;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      q.delete();
      m_active = 1'b0;
      m_first  = 1'b1;
      m_seq    = 0;
      m_drop   = 0;
      m_iters  = '0;
      t        = '0;
   endtask

   task automatic check_outputs();
      chk("busy", busy, 64'(m_active));
      chk("rec_valid", rec_valid, 64'(q.size() != 0));
      chk("drop_cnt", drop_cnt, 64'(m_drop));
      if (q.size() != 0) begin
         chk("rec_latency", rec_latency, q[0].lat);
         chk("rec_interval", rec_interval, q[0].intv);
         chk("rec_iters", rec_iters, q[0].iters);
         chk("rec_seq", rec_seq, q[0].seq);
      end
   endtask

   // Transaction-level view of one clock edge using the inputs now driven.
   task automatic model_edge();
      mrec_t r;
      bit    pop;
      bit    have;
      pop  = (q.size() != 0) && rec_ready;
      have = 1'b0;
      r    = '{default: '0};
      if (!m_active) begin
         if (mon_start && enable) begin
            r.intv  = m_first ? 32'd0 : t - m_prev;
            m_prev  = t;
            m_first = 1'b0;
            if (mon_done) begin
               r.lat   = 32'd0;
               r.iters = 32'(mon_iter);
               have    = 1'b1;
            end else begin
               m_active = 1'b1;
               m_st     = t;
               m_iters  = 32'(mon_iter);
               m_intv   = r.intv;
            end
         end
      end else begin
         if (mon_iter) m_iters++;
         if (mon_done) begin
            r.lat    = t - m_st;
            r.intv   = m_intv;
            r.iters  = m_iters;
            have     = 1'b1;
            m_active = 1'b0;
         end
      end
      if (pop) q.delete(0);
      if (have) begin
         r.seq = 32'(m_seq % 65536);
         m_seq++;
         if (q.size() < DEPTH) q.push_back(r);
         else if (m_drop < 65535) m_drop++;
      end
   endtask

   task automatic tick();
      check_outputs();
      model_edge();
      @(posedge ap_clk);
      @(negedge ap_clk);
      t++;
   endtask

   task automatic set_idle();
      mon_start = 1'b0;
      mon_done  = 1'b0;
      mon_iter  = 1'b0;
   endtask

   task automatic do_reset();
      set_idle();
      ap_rst_n = 1'b0;
      reset_model();
      repeat (2) @(negedge ap_clk);
      chk("rst_busy", busy, 64'd0);
      chk("rst_valid", rec_valid, 64'd0);
      chk("rst_drop", drop_cnt, 64'd0);
      chk("rst_lat", rec_latency, 64'd0);
      chk("rst_intv", rec_interval, 64'd0);
      chk("rst_iters", rec_iters, 64'd0);
      chk("rst_seq", rec_seq, 64'd0);
      ap_rst_n = 1'b1;
   endtask

   // gap idle cycles, then a transaction of latency lat with k iteration pulses.
   task automatic txn(input int gap, input int lat, input int k);
      int rem;
      set_idle();
      repeat (gap) tick();
      rem = k;
      for (int c = 0; c <= lat; c++) begin
         mon_start = (c == 0);
         mon_done  = (c == lat);
         mon_iter  = (rem > 0);
         if (rem > 0) rem--;
         tick();
      end
      set_idle();
   endtask

   task automatic expect_rec(input int lat, input int intv, input int iters, input int seq);
      chk("x_valid", rec_valid, 64'd1);
      chk("x_latency", rec_latency, 64'(lat));
      chk("x_interval", rec_interval, 64'(intv));
      chk("x_iters", rec_iters, 64'(iters));
      chk("x_seq", rec_seq, 64'(seq));
   endtask

   initial begin
      enable    = 1'b1;
      rec_ready = 1'b1;
      do_reset();

      // Start at 5, done at 15, then start at 25, done at 30.
      txn(5, 10, 3);
      expect_rec(10, 0, 3, 0);
      txn(9, 5, 0);
      expect_rec(5, 20, 0, 1);

      // Start and done together while idle.
      txn(3, 0, 1);
      chk("same_cycle_busy", busy, 64'd0);
      expect_rec(0, 9, 1, 2);

      // Disabled starts are ignored.
      tick();
      enable = 1'b0;
      txn(2, 3, 0);
      chk("disabled_no_rec", rec_valid, 64'd0);
      enable = 1'b1;

      // Enable dropping mid-flight still completes the transaction.
      set_idle();
      mon_start = 1'b1;
      tick();
      set_idle();
      enable = 1'b0;
      tick();
      mon_done = 1'b1;
      tick();
      set_idle();
      chk("en_drop_valid", rec_valid, 64'd1);
      chk("en_drop_lat", rec_latency, 64'd2);
      enable = 1'b1;
      tick();

      // Overflow: five records into a four-deep FIFO with no consumer.
      do_reset();
      rec_ready = 1'b0;
      repeat (5) txn(1, 2, 0);
      chk("ovf_drop", drop_cnt, 64'd1);
      rec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_seq", rec_seq, 64'(i));
         tick();
      end
      chk("drained_empty", rec_valid, 64'd0);

      // Full FIFO with done landing on a pop cycle.
      rec_ready = 1'b0;
      repeat (4) txn(1, 2, 0);
      tick();
      mon_start = 1'b1;
      tick();
      set_idle();
      tick();
      mon_done  = 1'b1;
      rec_ready = 1'b1;
      tick();
      set_idle();
      rec_ready = 1'b0;
      chk("full_pop_drop", drop_cnt, 64'd1);
      rec_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk("full_pop_seq", rec_seq, 64'(6 + j));
         tick();
      end

      // Reset while a transaction is in flight.
      mon_start = 1'b1;
      tick();
      set_idle();
      repeat (2) tick();
      chk("pre_rst_busy", busy, 64'd1);
      #2 ap_rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy, 64'd0);
      chk("async_rst_valid", rec_valid, 64'd0);
      reset_model();
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      txn(2, 3, 1);
      expect_rec(3, 0, 1, 0);

      // Random traffic.
      repeat (800) begin
         mon_start = ($urandom_range(0, 3) == 0);
         mon_done  = ($urandom_range(0, 4) == 0);
         mon_iter  = $urandom_range(0, 1) != 0;
         enable    = ($urandom_range(0, 7) != 0);
         rec_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      set_idle();
      check_outputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
